// File: rtl/sevenseg_scan_driver.sv
// N-digit multiplexed seven-segment driver: prescaled one-hot scan, double-buffered
// frame commit, leading-zero blanking, per-digit dp, enable gating, selectable polarity.
module sevenseg_scan_driver #(
  parameter int unsigned NDIGITS        = 4,
  parameter int unsigned DIVIDER        = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic [NDIGITS-1:0]     dp_in,
  input  logic                   blank_lz,
  input  logic                   enable,
  output logic [6:0]             dispseg,
  output logic                   dispdp,
  output logic [NDIGITS-1:0]     digsel,
  output logic                   frame
);

  localparam int unsigned VW = 4 * NDIGITS;
  localparam int unsigned CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam int unsigned IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [6:0]         SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic [NDIGITS-1:0] DIG_OFF = {NDIGITS{DIG_ACTIVE_LOW}};

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [VW-1:0]      act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic [NDIGITS-1:0] act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic               pend_vld_q, pend_vld_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic [NDIGITS-1:0] sel_q, sel_d;
  logic               frame_q, frame_d;

  logic               tc, wrap, hi_zero, blank, dp_bit;
  logic [3:0]         nib;
  logic [6:0]         seg_raw;
  logic [NDIGITS-1:0] sel_raw;

  function automatic logic [6:0] hex2seg(input logic [3:0] n);
    case (n)
      4'h0: hex2seg = 7'h3F;
      4'h1: hex2seg = 7'h06;
      4'h2: hex2seg = 7'h5B;
      4'h3: hex2seg = 7'h4F;
      4'h4: hex2seg = 7'h66;
      4'h5: hex2seg = 7'h6D;
      4'h6: hex2seg = 7'h7D;
      4'h7: hex2seg = 7'h07;
      4'h8: hex2seg = 7'h7F;
      4'h9: hex2seg = 7'h67;
      4'hA: hex2seg = 7'h77;
      4'hB: hex2seg = 7'h7C;
      4'hC: hex2seg = 7'h39;
      4'hD: hex2seg = 7'h5E;
      4'hE: hex2seg = 7'h79;
      default: hex2seg = 7'h71;
    endcase
  endfunction

  // Scan/commit next state; outputs are derived from the next-state index and buffer
  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    act_val_d  = act_val_q;
    act_dp_d   = act_dp_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    nib        = 4'h0;
    dp_bit     = 1'b0;
    hi_zero    = 1'b1;
    blank      = 1'b0;
    sel_raw    = '0;

    tc      = (cnt_q == CW'(DIVIDER - 1));
    wrap    = tc && (idx_q == IW'(NDIGITS - 1));
    cnt_d   = tc ? '0 : cnt_q + CW'(1);
    frame_d = wrap;

    if (wrap) begin
      idx_d = '0;
    end else if (tc) begin
      idx_d = idx_q + IW'(1);
    end

    if (wrap && pend_vld_q) begin
      act_val_d  = pend_val_q;
      act_dp_d   = pend_dp_q;
      pend_vld_d = 1'b0;
    end

    // A load on the commit edge lands in pending and waits for the next frame
    if (load) begin
      pend_val_d = value;
      pend_dp_d  = dp_in;
      pend_vld_d = 1'b1;
    end

    for (int i = NDIGITS - 1; i >= 0; i--) begin
      hi_zero = hi_zero & (act_val_d[4*i +: 4] == 4'h0);
      if (idx_d == IW'(i)) begin
        nib        = act_val_d[4*i +: 4];
        dp_bit     = act_dp_d[i];
        sel_raw[i] = 1'b1;
        blank      = blank_lz && (i != 0) && hi_zero;
      end
    end

    seg_raw = blank ? 7'h00 : hex2seg(nib);

    if (!enable) begin
      sel_raw = '0;
      seg_raw = 7'h00;
      dp_bit  = 1'b0;
    end

    seg_d = seg_raw ^ SEG_OFF;
    dp_d  = dp_bit ^ SEG_ACTIVE_LOW;
    sel_d = sel_raw ^ DIG_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      act_val_q  <= '0;
      act_dp_q   <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      seg_q      <= SEG_OFF;
      dp_q       <= SEG_ACTIVE_LOW;
      sel_q      <= DIG_OFF;
      frame_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      act_val_q  <= act_val_d;
      act_dp_q   <= act_dp_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      sel_q      <= sel_d;
      frame_q    <= frame_d;
    end
  end

  assign dispseg = seg_q;
  assign dispdp  = dp_q;
  assign digsel  = sel_q;
  assign frame   = frame_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Scoreboard bench for sevenseg_scan_driver: a 4-digit/DIVIDER=4 instance and a
// 1-digit/DIVIDER=1 active-low-segment instance.
module tb_sevenseg_scan_driver;

  typedef struct packed {
    logic [3:0] sel;
    logic [6:0] seg;
    logic       dp;
    logic       fr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, rst_n_b = 1'b0;
  logic        load_a = 1'b0, blz_a = 1'b0, en_a = 1'b1;
  logic [15:0] value_a = '0;
  logic [3:0]  dp_a = '0;
  logic [6:0]  seg_a;
  logic        dpo_a, frame_a;
  logic [3:0]  sel_a;
  logic        load_b = 1'b0, blz_b = 1'b0, en_b = 1'b1;
  logic [3:0]  value_b = '0;
  logic [0:0]  dp_b = '0;
  logic [6:0]  seg_b;
  logic        dpo_b, frame_b;
  logic [0:0]  sel_b;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  sevenseg_scan_driver #(.NDIGITS(4), .DIVIDER(4), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .load(load_a), .value(value_a), .dp_in(dp_a),
    .blank_lz(blz_a), .enable(en_a), .dispseg(seg_a), .dispdp(dpo_a),
    .digsel(sel_a), .frame(frame_a));

  sevenseg_scan_driver #(.NDIGITS(1), .DIVIDER(1), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n_b), .load(load_b), .value(value_b), .dp_in(dp_b),
    .blank_lz(blz_b), .enable(en_b), .dispseg(seg_b), .dispdp(dpo_b),
    .digsel(sel_b), .frame(frame_b));

  // Expected 4-digit scan: n cycles from a frame pulse; cycles off_lo..off_hi gated off
  task automatic push_frame(input logic [27:0] segs, input logic [3:0] dpv,
                            input int n, input int off_lo, input int off_hi);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      int d;
      d = (c / 4) % 4;
      e.fr = (c % 16 == 0);
      if (c >= off_lo && c <= off_hi) begin
        e.sel = 4'hF;
        e.seg = 7'h00;
        e.dp  = 1'b0;
      end else begin
        e.sel = ~(4'b0001 << d);
        e.seg = segs[7*d +: 7];
        e.dp  = dpv[d];
      end
      sb.push_back(e);
    end
  endtask

  task automatic wait_frame();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_a === 1'b1) return;
    end
    total++; bad++;
    $display("FAIL wait_frame got=no pulse exp=pulse within 40 cycles");
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total += 8;
    if (sel_a !== 4'hF)   begin bad++; $display("FAIL reset_digsel got=%h exp=f", sel_a); end
    if (seg_a !== 7'h00)  begin bad++; $display("FAIL reset_dispseg got=%h exp=00", seg_a); end
    if (dpo_a !== 1'b0)   begin bad++; $display("FAIL reset_dispdp got=%b exp=0", dpo_a); end
    if (frame_a !== 1'b0) begin bad++; $display("FAIL reset_frame got=%b exp=0", frame_a); end
    if (sel_b !== 1'b0)   begin bad++; $display("FAIL reset_b_digsel got=%b exp=0", sel_b); end
    if (seg_b !== 7'h7F)  begin bad++; $display("FAIL reset_b_dispseg got=%h exp=7f", seg_b); end
    if (dpo_b !== 1'b1)   begin bad++; $display("FAIL reset_b_dispdp got=%b exp=1", dpo_b); end
    if (frame_b !== 1'b0) begin bad++; $display("FAIL reset_b_frame got=%b exp=0", frame_b); end
    rst_n = 1'b1;
    rst_n_b = 1'b1;
  endtask

  task automatic test_scan();
    exp_t got, exp;
    int k;
    value_a = 16'h12AF; dp_a = 4'b0000; load_a = 1'b1;
    @(negedge clk); load_a = 1'b0;
    wait_frame();
    push_frame({7'h06, 7'h5B, 7'h77, 7'h71}, 4'b0000, 17, 99, 0);
    k = 0;
    while (sb.size() > 0) begin
      if (k > 0) @(negedge clk);
      got = {sel_a, seg_a, dpo_a, frame_a}; exp = sb.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL scan_12af cyc=%0d got=%h exp=%h", k, got, exp); end
      k++;
    end
  endtask

  task automatic test_last_wins();
    exp_t got, exp;
    int k;
    blz_a = 1'b1; value_a = 16'h0000; load_a = 1'b1;
    @(negedge clk); value_a = 16'h00C3;
    @(negedge clk); load_a = 1'b0;
    wait_frame();
    push_frame({7'h00, 7'h00, 7'h39, 7'h4F}, 4'b0000, 16, 99, 0);
    k = 0;
    while (sb.size() > 0) begin
      if (k > 0) @(negedge clk);
      got = {sel_a, seg_a, dpo_a, frame_a}; exp = sb.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL last_wins_blank cyc=%0d got=%h exp=%h", k, got, exp); end
      if (k == 15) blz_a = 1'b0;
      k++;
    end
    wait_frame();
    push_frame({7'h3F, 7'h3F, 7'h39, 7'h4F}, 4'b0000, 16, 99, 0);
    k = 0;
    while (sb.size() > 0) begin
      if (k > 0) @(negedge clk);
      got = {sel_a, seg_a, dpo_a, frame_a}; exp = sb.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL last_wins_noblank cyc=%0d got=%h exp=%h", k, got, exp); end
      // load presented on the wrap edge itself
      if (k == 15) begin load_a = 1'b1; value_a = 16'h0000; dp_a = 4'b0100; blz_a = 1'b1; end
      k++;
    end
  endtask

  task automatic test_dp_blank();
    exp_t got, exp;
    int k;
    wait_frame();
    load_a = 1'b0;
    push_frame({7'h00, 7'h00, 7'h39, 7'h4F}, 4'b0000, 16, 99, 0);
    push_frame({7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0100, 17, 99, 0);
    k = 0;
    while (sb.size() > 0) begin
      if (k > 0) @(negedge clk);
      got = {sel_a, seg_a, dpo_a, frame_a}; exp = sb.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL dp_blank cyc=%0d got=%h exp=%h", k, got, exp); end
      k++;
    end
  endtask

  task automatic test_frame_load();
    exp_t got, exp;
    int k;
    push_frame({7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0100, 16, 99, 0);
    push_frame({7'h06, 7'h5B, 7'h77, 7'h71}, 4'b0000, 17, 99, 0);
    k = 0;
    while (sb.size() > 0) begin
      if (k > 0) @(negedge clk);
      got = {sel_a, seg_a, dpo_a, frame_a}; exp = sb.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL frame_load cyc=%0d got=%h exp=%h", k, got, exp); end
      if (k == 0) begin load_a = 1'b1; value_a = 16'h12AF; dp_a = 4'b0000; end
      else        load_a = 1'b0;
      k++;
    end
  endtask

  task automatic test_enable();
    exp_t got, exp;
    int k;
    push_frame({7'h06, 7'h5B, 7'h77, 7'h71}, 4'b0000, 33, 6, 20);
    k = 0;
    while (sb.size() > 0) begin
      if (k > 0) @(negedge clk);
      got = {sel_a, seg_a, dpo_a, frame_a}; exp = sb.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL enable_gate cyc=%0d got=%h exp=%h", k, got, exp); end
      if (k == 5)  en_a = 1'b0;
      if (k == 20) en_a = 1'b1;
      k++;
    end
  endtask

  task automatic test_small_scan();
    exp_t got, exp;
    int k;
    value_b = 4'h5; dp_b = 1'b1; load_b = 1'b1;
    @(negedge clk); load_b = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) sb.push_back('{sel: 4'b0001, seg: 7'h12, dp: 1'b0, fr: 1'b1});
    k = 0;
    while (sb.size() > 0) begin
      if (k > 0) @(negedge clk);
      got = {4'(sel_b), seg_b, dpo_b, frame_b}; exp = sb.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL small_scan cyc=%0d got=%h exp=%h", k, got, exp); end
      k++;
    end
  endtask

  task automatic test_async_reset();
    exp_t got, exp;
    int k;
    #2 rst_n_b = 1'b0;
    #1;
    total += 4;
    if (seg_b !== 7'h7F)  begin bad++; $display("FAIL async_rst_dispseg got=%h exp=7f", seg_b); end
    if (sel_b !== 1'b0)   begin bad++; $display("FAIL async_rst_digsel got=%b exp=0", sel_b); end
    if (dpo_b !== 1'b1)   begin bad++; $display("FAIL async_rst_dispdp got=%b exp=1", dpo_b); end
    if (frame_b !== 1'b0) begin bad++; $display("FAIL async_rst_frame got=%b exp=0", frame_b); end
    @(negedge clk); rst_n_b = 1'b1;
    for (int i = 0; i < 4; i++) sb.push_back('{sel: 4'b0001, seg: 7'h40, dp: 1'b1, fr: 1'b1});
    k = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      got = {4'(sel_b), seg_b, dpo_b, frame_b}; exp = sb.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", k, got, exp); end
      k++;
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_last_wins();
    test_dp_blank();
    test_frame_load();
    test_enable();
    test_small_scan();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
